// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared constants for the HI/LO multiply-divide issue path: op encodings,
// controller state encodings and a small op-classification helper.
package muldiv_issue_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] mtMultiply         = 3'd0;
  localparam logic [2:0] mtMultiplyUnsigned = 3'd1;
  localparam logic [2:0] mtMSUB             = 3'd2;
  localparam logic [2:0] mtDivide           = 3'd3;
  localparam logic [2:0] mtDivideUnsigned   = 3'd4;
  localparam logic [2:0] mtSetHI            = 3'd5;
  localparam logic [2:0] mtSetLO            = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } md_state_e;

  // Direct HI/LO writes complete inside the launch cycle and never raise busy.
  function automatic logic is_hilo_write(input logic [2:0] op);
    return (op == mtSetHI) || (op == mtSetLO);
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller in front of the HI/LO multiply-divide unit: one-entry request
// buffer, start pulse, busy tracking and pipeline stall. Macro MULDIV_PERF_CNT_EN adds perf counters.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int CTRL_W = 3
`ifdef MULDIV_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [CTRL_W-1:0] req_ctrl,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              req_ready,
  input  logic              rd_valid,
  input  logic              rd_sel,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  output logic              stall,
  output logic              md_start,
  output logic [CTRL_W-1:0] md_ctrl,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_busy,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo
`ifdef MULDIV_PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_ops
  , output logic [PERF_W-1:0] perf_stall_cyc
`endif
);

  md_state_e         state, state_nxt;
  logic              pend_valid;
  logic [CTRL_W-1:0] pend_ctrl;
  logic [DATA_W-1:0] pend_a, pend_b;
  logic              can_launch, take_pend, take_req, launch, accept;

  // HI/LO is stable and a new op may start whenever the unit is idle or just finished.
  assign can_launch = (state == IDLE) | ((state == RUN) & ~md_busy);
  assign req_ready  = ~pend_valid & ~flush;
  assign accept     = req_valid & req_ready;
  assign take_pend  = can_launch & pend_valid & ~flush;
  assign take_req   = can_launch & accept;
  assign launch     = take_pend | take_req;

  assign rd_ready = ~pend_valid & can_launch;
  assign rd_data  = rd_sel ? md_hi : md_lo;
  assign stall    = (req_valid & ~req_ready) | (rd_valid & ~rd_ready);

  // A request that can launch immediately bypasses the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
    end else if (flush) begin
      pend_valid <= 1'b0;
    end else if (accept && !take_req) begin
      pend_valid <= 1'b1;
    end else if (take_pend) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_ctrl <= req_ctrl;
      pend_a    <= req_a;
      pend_b    <= req_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_ctrl <= '0;
      md_a    <= '0;
      md_b    <= '0;
    end else if (launch) begin
      md_ctrl <= pend_valid ? pend_ctrl : req_ctrl;
      md_a    <= pend_valid ? pend_a    : req_a;
      md_b    <= pend_valid ? pend_b    : req_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = launch ? LAUNCH : IDLE;
      LAUNCH:  state_nxt = is_hilo_write(md_ctrl) ? IDLE : RUN;
      RUN:     if (!md_busy) state_nxt = launch ? LAUNCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_start = (state == LAUNCH);
  end

`ifdef MULDIV_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops       <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (launch) perf_ops       <= perf_ops + 1'b1;
      if (stall)  perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl with a behavioural HI/LO multiply-divide unit
// (latency 5 for multiplies, 10 for divides); scoreboard queues for launches and reads.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  logic        clk, reset_n;
  logic        req_valid, req_ready, rd_valid, rd_sel, rd_ready, flush, stall;
  logic [2:0]  req_ctrl, md_ctrl;
  logic [31:0] req_a, req_b, rd_data, md_a, md_b, md_hi, md_lo;
  logic        md_start, md_busy;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] perf_ops, perf_stall_cyc;
`endif

  muldiv_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush), .stall(stall),
    .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
`ifdef MULDIV_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // ---------------- behavioural multiply-divide unit ----------------
  logic        u_busy;
  logic [3:0]  u_cnt;
  logic [2:0]  u_op;
  logic [31:0] u_a, u_b, u_hi, u_lo;

  function automatic logic [63:0] unit_res(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    logic signed [63:0] sa, sb;
    logic [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = {hi, lo};
    case (op)
      mtMultiply:         r = sa * sb;
      mtMultiplyUnsigned: r = {32'b0, a} * {32'b0, b};
      mtMSUB:             r = {hi, lo} - (sa * sb);
      mtDivide:           if (b != 0) r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      mtDivideUnsigned:   if (b != 0) r = {a % b, a / b};
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_busy <= 1'b0; u_cnt <= '0; u_op <= '0; u_a <= '0; u_b <= '0; u_hi <= '0; u_lo <= '0;
    end else if (md_start) begin
      u_op <= md_ctrl; u_a <= md_a; u_b <= md_b;
      case (md_ctrl)
        mtSetHI: u_hi <= md_a;
        mtSetLO: u_lo <= md_a;
        mtMultiply, mtMultiplyUnsigned, mtMSUB: begin u_busy <= 1'b1; u_cnt <= 4'd5; end
        mtDivide, mtDivideUnsigned:             begin u_busy <= 1'b1; u_cnt <= 4'd10; end
        default: ;
      endcase
    end else if (u_busy) begin
      u_cnt <= u_cnt - 4'd1;
      if (u_cnt == 4'd1) begin
        u_busy <= 1'b0;
        {u_hi, u_lo} <= unit_res(u_op, u_a, u_b, u_hi, u_lo);
      end
    end
  end

  assign md_busy = u_busy;
  assign md_hi   = u_hi;
  assign md_lo   = u_lo;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [2:0] ctrl; logic [31:0] a; logic [31:0] b; } launch_t;
  typedef struct { int cyc; logic [31:0] data; } read_t;
  launch_t lq[$];
  read_t   rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, gcyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, gcyc);
  endtask

  always @(negedge clk) begin
    if (reset_n && md_start) begin
      if (lq.size() == 0) fail_now("launch_unexpected");
      else begin
        launch_t e;
        e = lq.pop_front();
        if (e.cyc >= 0) chk("launch_cycle", gcyc, e.cyc);
        chk("launch_ctrl", {29'b0, md_ctrl}, {29'b0, e.ctrl});
        chk("launch_a", md_a, e.a);
        chk("launch_b", md_b, e.b);
      end
    end
    if (reset_n && rd_valid && rd_ready) begin
      if (rq.size() == 0) fail_now("read_unexpected");
      else begin
        read_t r;
        r = rq.pop_front();
        if (r.cyc >= 0) chk("read_cycle", gcyc, r.cyc);
        chk("read_data", rd_data, r.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, b, input int lcyc);
    req_valid = 1'b1; req_ctrl = op; req_a = a; req_b = b;
    lq.push_back('{lcyc, op, a, b});
  endtask

  // Called at the start of a cycle; holds the read until serviced, then drops it.
  task automatic read_op(input logic sel, input logic [31:0] exp, input int at);
    bit seen;
    seen = 0;
    rd_sel = sel; rd_valid = 1'b1;
    rq.push_back('{at, exp});
    for (int n = 0; n < 40; n++) begin
      #1;
      if (rd_ready) begin seen = 1; break; end
      step();
    end
    if (!seen) begin
      fail_now("read_timeout");
      void'(rq.pop_back());
    end
    step();
    rd_valid = 1'b0;
  endtask

  int c0;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] p0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_ctrl = '0; req_a = '0; req_b = '0;
    rd_valid = 1'b0; rd_sel = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_md_start", {31'b0, md_start}, 32'd0);
    chk("rst_md_ctrl", {29'b0, md_ctrl}, 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_md_b", md_b, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rd_ready", {31'b0, rd_ready}, 32'd1);
`ifdef MULDIV_PERF_CNT_EN
    chk("rst_perf_ops", perf_ops, 32'd0);
    chk("rst_perf_stall", perf_stall_cyc, 32'd0);
`endif
    reset_n = 1'b1;

    // MULT 3 x -2 with MFLO held from cycle 1
    step(); c0 = gcyc;
    req(mtMultiply, 32'd3, 32'hFFFFFFFE, c0 + 1);
    #1 chk("mult_acc", {31'b0, req_ready}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        req_valid = 1'b0; rd_sel = 1'b0; rd_valid = 1'b1;
        rq.push_back('{c0 + 7, 32'hFFFFFFFA});
      end
      if (k == 8) rd_valid = 1'b0;
      #1;
      if (k <= 7) chk($sformatf("mult_stall_c%0d", k), {31'b0, stall}, (k <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("mult_start_c%0d", k), {31'b0, md_start}, (k == 1) ? 32'd1 : 32'd0);
    end
    read_op(1'b1, 32'hFFFFFFFF, -1);

    // DIVU 100 / 7 then MFHI, MFLO
    step(); c0 = gcyc;
    req(mtDivideUnsigned, 32'd100, 32'd7, c0 + 1);
    step(); req_valid = 1'b0;
    read_op(1'b1, 32'd2, c0 + 12);
    read_op(1'b0, 32'd14, -1);

    // MTHI, then a same-cycle read and request in IDLE
    step(); c0 = gcyc;
    req(mtSetHI, 32'h1234, 32'd0, c0 + 1);
    step(); req_valid = 1'b0;
    #1 chk("mthi_start", {31'b0, md_start}, 32'd1);
    step(); step();
    read_op(1'b1, 32'h1234, c0 + 3);
    c0 = gcyc;
    req(mtSetHI, 32'h5678, 32'd0, c0 + 1);
    rd_sel = 1'b1; rd_valid = 1'b1;
    rq.push_back('{c0, 32'h1234});
    #1 chk("order_req_ready", {31'b0, req_ready}, 32'd1);
    chk("order_rd_ready", {31'b0, rd_ready}, 32'd1);
    step(); req_valid = 1'b0; rd_valid = 1'b0;
    step();
    read_op(1'b1, 32'h5678, -1);

    // MULT followed back-to-back by MULTU 0xFFFFFFFF x 2
    step(); c0 = gcyc;
    req(mtMultiply, 32'd5, 32'd6, c0 + 1);
    step();
    req(mtMultiplyUnsigned, 32'hFFFFFFFF, 32'd2, c0 + 8);
    #1 chk("b2b_acc2", {31'b0, req_ready}, 32'd1);
    for (int k = 2; k <= 8; k++) begin
      step();
      if (k == 2) req_valid = 1'b0;
      #1 chk($sformatf("b2b_ready_c%0d", k), {31'b0, req_ready}, (k == 8) ? 32'd1 : 32'd0);
    end
    step();
    read_op(1'b1, 32'd1, -1);
    read_op(1'b0, 32'hFFFFFFFE, -1);

    // buffered request flushed while the first op runs
    step(); c0 = gcyc;
`ifdef MULDIV_PERF_CNT_EN
    p0 = perf_ops;
`endif
    req(mtMultiply, 32'd7, 32'd7, c0 + 1);
    step();
    req_valid = 1'b1; req_ctrl = mtDivide; req_a = 32'd9; req_b = 32'd3;
    step(); req_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_block", {31'b0, req_ready}, 32'd0);
    step(); flush = 1'b0;
    #1 chk("flush_cleared", {31'b0, req_ready}, 32'd1);
    step();
    read_op(1'b0, 32'd49, c0 + 7);
    read_op(1'b1, 32'd0, -1);
`ifdef MULDIV_PERF_CNT_EN
    chk("flush_perf_ops", perf_ops, p0 + 32'd1);
`endif

    // reset during RUN
    step(); c0 = gcyc;
    req(mtMultiply, 32'd2, 32'd3, c0 + 1);
    step(); req_valid = 1'b0;
    step(); step();
    #1 reset_n = 1'b0;
    #1 chk("rst_run_start", {31'b0, md_start}, 32'd0);
    chk("rst_run_rd_ready", {31'b0, rd_ready}, 32'd1);
    chk("rst_run_md_a", md_a, 32'd0);
    #3 reset_n = 1'b1;
    step();
    read_op(1'b1, 32'd0, -1);
    read_op(1'b0, 32'd0, -1);

    // undefined op code: launched, RUN exits at once, HI/LO untouched
    step(); c0 = gcyc;
    req(3'd7, 32'd1, 32'd1, c0 + 1);
    step(); req_valid = 1'b0;
    read_op(1'b0, 32'd0, c0 + 2);

    repeat (3) step();
    chk("launch_q_empty", lq.size(), 32'd0);
    chk("read_q_empty", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
